// File: rtl/nn_pkg.sv
// Shared types and constants for the node-network output collector.
package nn_pkg;

    localparam int NN_DW = 21;
    localparam int NODES = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]              node;
        logic signed [NN_DW-1:0] out0;
        logic signed [NN_DW-1:0] out1;
        logic                    cls;
        logic                    last;
    } nn_rec_t;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector; a level already high out of reset counts as an edge.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/nn_out_collector.sv
// Captures the eight per-node results on their ready edges, then streams four
// per-node records with a class bit over valid/ready.
module nn_out_collector
    import nn_pkg::*;
#(
    parameter int DW = NN_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] out0_node0,
    input  logic signed [DW-1:0] out0_node1,
    input  logic signed [DW-1:0] out0_node2,
    input  logic signed [DW-1:0] out0_node3,
    input  logic signed [DW-1:0] out1_node0,
    input  logic signed [DW-1:0] out1_node1,
    input  logic signed [DW-1:0] out1_node2,
    input  logic signed [DW-1:0] out1_node3,
    input  logic                 out10_ready_node0,
    input  logic                 out10_ready_node1,
    input  logic                 out10_ready_node2,
    input  logic                 out10_ready_node3,
    input  logic                 out11_ready_node0,
    input  logic                 out11_ready_node1,
    input  logic                 out11_ready_node2,
    input  logic                 out11_ready_node3,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_node,
    output logic signed [DW-1:0] res_out0,
    output logic signed [DW-1:0] res_out1,
    output logic                 res_class,
    output logic                 res_last,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 busy
);

    // [o][n]: output o of node n
    logic [1:0][NODES-1:0] flag, rise, cap_q;
    logic signed [DW-1:0]  din    [2][NODES];
    logic signed [DW-1:0]  slot_q [2][NODES];
    state_e                state_q;
    logic [1:0]            rd_idx_q;
    logic                  frame_done_q, overrun_q;

    assign flag[0] = {out10_ready_node3, out10_ready_node2, out10_ready_node1, out10_ready_node0};
    assign flag[1] = {out11_ready_node3, out11_ready_node2, out11_ready_node1, out11_ready_node0};
    assign din[0]  = '{out0_node0, out0_node1, out0_node2, out0_node3};
    assign din[1]  = '{out1_node0, out1_node1, out1_node2, out1_node3};

    for (genvar o = 0; o < 2; o++) begin : g_out
        for (genvar n = 0; n < NODES; n++) begin : g_node
            rise_det u_rise (
                .clk    (clk),
                .rst_n  (rst_n),
                .d_i    (flag[o][n]),
                .rise_o (rise[o][n])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            rd_idx_q     <= '0;
            cap_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int o = 0; o < 2; o++)
                for (int n = 0; n < NODES; n++)
                    slot_q[o][n] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    for (int o = 0; o < 2; o++)
                        for (int n = 0; n < NODES; n++)
                            if (rise[o][n]) slot_q[o][n] <= din[o][n];
                    if ((cap_q | rise) == '1) begin
                        state_q  <= DRAIN;
                        rd_idx_q <= '0;
                        cap_q    <= '0;
                    end else begin
                        cap_q <= cap_q | rise;
                    end
                end
                DRAIN: begin
                    // slots are frozen while draining; any new edge is lost
                    if (|rise) overrun_q <= 1'b1;
                    if (res_ready) begin
                        rd_idx_q <= rd_idx_q + 2'd1;
                        if (rd_idx_q == 2'(NODES - 1)) begin
                            state_q      <= COLLECT;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign busy       = (state_q == DRAIN);
    assign res_valid  = busy;
    assign res_node   = busy ? rd_idx_q : 2'd0;
    assign res_out0   = busy ? slot_q[0][rd_idx_q] : '0;
    assign res_out1   = busy ? slot_q[1][rd_idx_q] : '0;
    assign res_class  = res_out1 > res_out0;
    assign res_last   = busy && (rd_idx_q == 2'(NODES - 1));
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_nn_out_collector.sv
// Directed bench with a record scoreboard for nn_out_collector.
module tb_nn_out_collector;
    import nn_pkg::*;

    localparam int DW = NN_DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [DW-1:0] o0 [4];
    logic signed [DW-1:0] o1 [4];
    logic r0 [4];
    logic r1 [4];
    logic res_ready = 1'b0;

    logic                 res_valid, res_class, res_last, frame_done, overrun, busy;
    logic [1:0]           res_node;
    logic signed [DW-1:0] res_out0, res_out1;

    logic signed [DW-1:0] m0 [4];
    logic signed [DW-1:0] m1 [4];
    nn_rec_t sbq[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nn_out_collector #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .out0_node0(o0[0]), .out0_node1(o0[1]), .out0_node2(o0[2]), .out0_node3(o0[3]),
        .out1_node0(o1[0]), .out1_node1(o1[1]), .out1_node2(o1[2]), .out1_node3(o1[3]),
        .out10_ready_node0(r0[0]), .out10_ready_node1(r0[1]),
        .out10_ready_node2(r0[2]), .out10_ready_node3(r0[3]),
        .out11_ready_node0(r1[0]), .out11_ready_node1(r1[1]),
        .out11_ready_node2(r1[2]), .out11_ready_node3(r1[3]),
        .res_valid(res_valid), .res_ready(res_ready), .res_node(res_node),
        .res_out0(res_out0), .res_out1(res_out1), .res_class(res_class),
        .res_last(res_last), .frame_done(frame_done), .overrun(overrun), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    task automatic raise(input int o, input int n, input logic signed [DW-1:0] v);
        if (o == 0) begin o0[n] = v; m0[n] = v; r0[n] = 1'b1; end
        else        begin o1[n] = v; m1[n] = v; r1[n] = 1'b1; end
    endtask

    task automatic lower_all();
        for (int n = 0; n < 4; n++) begin r0[n] = 1'b0; r1[n] = 1'b0; end
    endtask

    task automatic push_frame();
        nn_rec_t e;
        for (int n = 0; n < 4; n++) begin
            e.node = 2'(n);
            e.out0 = m0[n];
            e.out1 = m1[n];
            e.cls  = m1[n] > m0[n];
            e.last = (n == 3);
            sbq.push_back(e);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_node"},  res_node, 0);
        chk({tag, "_out0"},  res_out0, 0);
        chk({tag, "_out1"},  res_out1, 0);
        chk({tag, "_class"}, res_class, 0);
        chk({tag, "_last"},  res_last, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    // Accept nacc records, holding ready low for 'stall' cycles before each accept.
    task automatic drain(input int stall, input int nacc);
        int acc = 0;
        int w = 0;
        int cyc = 0;
        nn_rec_t e;
        while (acc < nacc && cyc < 200) begin
            @(negedge clk);
            cyc++;
            res_ready = 1'b0;
            if (res_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(sbq.size()), 1);
                    break;
                end
                e = sbq[0];
                chk("rec_node",  res_node,   e.node);
                chk("rec_out0",  res_out0,   e.out0);
                chk("rec_out1",  res_out1,   e.out1);
                chk("rec_class", res_class,  e.cls);
                chk("rec_last",  res_last,   e.last);
                chk("rec_busy",  busy,       1);
                chk("rec_fdone", frame_done, 0);
                if (w >= stall) begin
                    res_ready = 1'b1;
                    void'(sbq.pop_front());
                    acc++;
                    w = 0;
                end else begin
                    w++;
                end
            end
        end
        chk("accept_count", acc, nacc);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        res_ready = 1'b0;
        chk("fdone_pulse", frame_done, 1);
        chk("valid_after", res_valid, 0);
        @(negedge clk);
        chk("fdone_single", frame_done, 0);
    endtask

    initial begin
        // Frame 1: all flags high through reset
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        @(negedge clk);
        chk_idle("reset");
        chk("reset_overrun", overrun, 0);
        tick();
        rst_n = 1'b1;
        push_frame();
        @(negedge clk);
        chk("release_idle", res_valid, 0);
        @(negedge clk);
        chk("next_cycle_valid", res_valid, 1);
        drain(0, 4);
        finish_frame();
        chk("f1_overrun", overrun, 0);
        lower_all();
        tick();

        // Frame 2: staggered arrival
        raise(0, 0, -5);
        tick(); tick();
        raise(1, 0, 7);
        tick();
        @(negedge clk);
        chk("partial_idle", res_valid, 0);
        tick();
        for (int n = 1; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        drain(0, 4);
        finish_frame();
        lower_all();
        tick();

        // Frame 3: backpressure 0,0,1
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        drain(2, 4);
        finish_frame();
        lower_all();
        tick();

        // Frame 4: signed extremes and a tie
        raise(0, 0, -1048576);
        raise(1, 0, 1048575);
        raise(0, 1, 54000);
        raise(1, 1, 54000);
        for (int n = 2; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        drain(0, 4);
        finish_frame();
        lower_all();
        tick();

        // Frame 5: node2 out1 re-raised during DRAIN
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        tick();
        r1[2] = 1'b0;
        tick();
        r1[2] = 1'b1;
        o1[2] = rnd();
        tick();
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        chk("overrun_valid", res_valid, 1);
        drain(1, 4);
        finish_frame();
        chk("overrun_sticky", overrun, 1);

        // Frame 6: node2 out1 still high must not count
        for (int n = 0; n < 4; n++) begin
            r0[n] = 1'b0;
            if (n != 2) r1[n] = 1'b0;
        end
        tick();
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            if (n != 2) raise(1, n, rnd());
        end
        tick(); tick(); tick();
        @(negedge clk);
        chk("await_fresh_edge", res_valid, 0);
        r1[2] = 1'b0;
        tick();
        raise(1, 2, rnd());
        push_frame();
        drain(0, 4);
        finish_frame();
        chk("overrun_still", overrun, 1);
        lower_all();
        tick();

        // Frame 7: reset after two accepts
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        drain(0, 2);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        chk("midreset_overrun", overrun, 0);
        sbq.delete();
        lower_all();
        tick();
        rst_n = 1'b1;
        tick();

        // Frame 8: clean frame after reset
        for (int n = 0; n < 4; n++) begin
            raise(0, n, rnd());
            raise(1, n, rnd());
        end
        push_frame();
        drain(0, 4);
        finish_frame();
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nn_out_collector.md
# nn_out_collector

Downstream stage of the 2-layer node network (`top`). It watches the eight per-node output-ready flags and captures each 21-bit signed result on the rising edge of its flag. Once all eight results of a frame are held, it streams them out as four per-node records over a valid/ready handshake, tagging each record with a 1-bit class decision. It also reports frame completion and overrun.

## Interface
Parameters:
- `DW`, 21, width of each signed result word; must match `top` output width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `out0_node0..3`  in  DW  signed layer-2 output 0 of node n, from `top`.
- `out1_node0..3`  in  DW  signed layer-2 output 1 of node n.
- `out10_ready_node0..3`  in  1  out0 of node n valid (level, may stay high).
- `out11_ready_node0..3`  in  1  out1 of node n valid (level, may stay high).
- `res_valid`  out  1  record available.
- `res_ready`  in  1  consumer accepts record.
- `res_node`  out  2  node index of record.
- `res_out0`  out  DW  captured out0 of `res_node`.
- `res_out1`  out  DW  captured out1 of `res_node`.
- `res_class`  out  1  1 iff res_out1 > res_out0 (signed); ties give 0.
- `res_last`  out  1  high with the node-3 record.
- `frame_done`  out  1  one-cycle pulse after the node-3 record is accepted.
- `overrun`  out  1  sticky; set when a ready edge is dropped; cleared only by reset.
- `busy`  out  1  high in DRAIN.

## Operation
- 8 edge detectors, one per ready flag: `prev` register resets to 0; edge = flag & ~prev, so a flag already high on the first cycle after reset counts as an edge.
- 8-bit `captured` mask, one bit per (node, output).
- States: COLLECT (reset state) and DRAIN.
- COLLECT: on an edge for slot k, latch the matching data input into slot k and set `captured[k]`. Any number of edges may occur in one cycle; all are captured. An edge on an already-captured slot overwrites the data (latest wins); `overrun` is not set.
- COLLECT -> DRAIN on the clock edge where `captured` becomes all-ones (including that cycle's captures). `rd_idx` is set to 0 and `captured` is cleared.
- DRAIN: `res_valid`=1. Records are presented in node order 0,1,2,3 from the slot registers. Outputs hold stable while `res_valid & ~res_ready`.
- On `res_valid & res_ready`, `rd_idx` increments. When the record with `rd_idx`=3 is accepted: go to COLLECT and pulse `frame_done` next cycle.
- Edges in DRAIN, including the final-handshake cycle, are dropped: no capture, `overrun` set. `prev` keeps tracking, so a flag still high afterwards gives no new edge.
- `res_class` is combinational from the presented slot; compare at full DW signed.
- Reset mid-operation: everything returns to its reset value immediately, and a partial frame is discarded.

## Timing
- Reset values: `res_valid`=0, `res_node`=0, `res_out0`=0, `res_out1`=0, `res_class`=0, `res_last`=0, `frame_done`=0, `overrun`=0, `busy`=0. Internally, state=COLLECT, `captured`=0, `prev`=0, slots=0.
- Latency: the final missing edge is sampled at edge T, and `res_valid` is high from T+1.
- With `res_ready` held high, the 4 records occupy cycles T+1..T+4. `frame_done` is high in T+5, and COLLECT accepts new edges from T+5.
- `res_valid` never drops without a handshake; the record must not change while stalled.
- Throughput: 1 record per cycle; the minimum frame period is 5 cycles after the last capture.

## Structure
- Package `nn_pkg`: `DW` default, `NODES`=4, state enum {COLLECT, DRAIN}, packed struct `nn_rec_t` {node, out0, out1, cls, last}.
- Sub-module `rise_det`: a 1-bit registered rising-edge detector with async active-low reset, instantiated 8 times.
- Slot storage is a 2x4 array of DW registers; the output mux is indexed by `rd_idx`.

## Test plan
- Reset with all ready flags high: after release, the 8 edges are captured in one cycle. `res_valid` is high the next cycle; node0 record first, and `overrun`=0.
- Staggered flags: node0 out0=-5 at cycle 2, out1=7 at cycle 4, others by cycle 6. Expect record0 to have `res_out0`=-5, `res_out1`=7, `res_class`=1, and `res_last` only on node3.
- Backpressure: `res_ready` toggles 0,0,1 per record. Fields stay stable during stalls, exactly 4 handshakes occur, and `frame_done` pulses once, one cycle after the node3 accept.
- Extremes: out0=-1048576 and out1=1048575 give class 1; out0=out1=54000 gives class 0 (tie).
- Overrun: drop node2's out11 flag, then raise it again during DRAIN. Expect `overrun`=1 (sticky), the frame emitted unchanged, and the next frame waiting for a fresh edge.
- Mid-DRAIN reset: assert `rst_n`=0 after 2 accepts. All outputs are 0 immediately, and after release the block collects a new frame with no stale records.
